uart_baud_gen_frac: RTL and testbench
=====================================

Name: uart_baud_gen_frac

Overview:
Next-generation UART baud tick generator with a fractional divider. A runtime-programmable divisor sets the baud rate; the generator emits a single-cycle rx oversample tick and a phase-locked tx bit tick. It replaces the fixed-rate generator feeding the UART rx/tx engines, so one build can support several baud rates and clock frequencies.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz; used only for reset defaults.
DEFAULT_BAUD, 115200, baud rate loaded at reset.
OVERSAMPLE, 16, rx ticks per tx tick; must be at least 2.
DIV_WIDTH, 16, width of the integer divisor.
FRAC_BITS, 4, width of the fractional divisor, in units of 1/2^FRAC_BITS clock.

Ports:
clk_50m  in  1  single system clock; all logic is on its rising edge.
rst  in  1  synchronous reset, active-high.
enable  in  1  1 = generate ticks; 0 = freeze all state.
div_int  in  DIV_WIDTH  integer clocks per rx tick; values below 2 are clamped to 2.
div_frac  in  FRAC_BITS  fractional clocks per rx tick.
div_load  in  1  one-cycle strobe that captures div_int and div_frac.
rxclk_en  out  1  one-cycle rx oversample tick.
txclk_en  out  1  one-cycle tx bit tick; always coincident with an rxclk_en.
resync  in  1  present only when BAUD_RESYNC_EN is defined.

Behaviour:
- Clocking and reset: one clock, clk_50m; reset rst is synchronous and active-high.
- Divisor: D = div_int + div_frac/2^FRAC_BITS clock cycles per rx tick.
- Reset defaults:
  - DEF_INT = CLK_HZ/(DEFAULT_BAUD*OVERSAMPLE), integer division.
  - DEF_FRAC = (CLK_HZ*2^FRAC_BITS/(DEFAULT_BAUD*OVERSAMPLE)) mod 2^FRAC_BITS.
  - With the default parameters: DEF_INT = 27, DEF_FRAC = 2.
- State registers:
  - active divisor (int, frac);
  - pending shadow divisor plus a pending flag;
  - down-counter cnt, DIV_WIDTH bits;
  - fractional accumulator facc, FRAC_BITS bits;
  - oversample counter os_cnt, ceil(log2(OVERSAMPLE)) bits.
- While rst = 1:
  - active divisor <= defaults; pending flag = 0; cnt = 0; facc = 0; os_cnt = 0.
  - rxclk_en = 0 and txclk_en = 0.
- rx tick:
  - rxclk_en = enable & ~rst & (cnt == 0). It is a combinational decode of registered state and has no extra latency.
  - The first tick occurs on the first enabled cycle after reset release. rxclk_en and txclk_en are both 1 on that cycle.
- On each rx tick:
  - Compute {carry, facc_next} = facc + frac_sel and P = int_sel + carry.
  - Update: cnt <= P-1; facc <= facc_next; active <= sel.
  - The next tick therefore follows exactly P cycles later. Over 2^FRAC_BITS ticks, the mean period equals D.
- Otherwise, while enable = 1 and cnt != 0: cnt <= cnt-1.
- Divisor selection ("sel" above) at a tick:
  - div_load on the same cycle: use the port values.
  - else, if the pending flag is set: use the shadow.
  - else: use the active divisor.
- div_load off a tick cycle:
  - shadow <= ports; pending flag <= 1.
  - The pending flag clears on the next tick.
  - A later div_load before that tick overwrites the shadow (last load wins).
  - The period already in progress is never shortened or extended.
- Clamp: if int_sel < 2, 2 is used. This keeps P ≥ 2, so ticks are never back-to-back.
- tx tick:
  - os_cnt increments on each rx tick and wraps from OVERSAMPLE-1 to 0.
  - txclk_en = rxclk_en & (os_cnt == 0).
  - tx ticks therefore occur every OVERSAMPLE rx ticks, aligned to the rx tick grid.
- enable = 0:
  - cnt, facc, os_cnt and the active divisor hold; both outputs are 0.
  - div_load is still captured into the shadow.
  - On re-enable, counting resumes from the held cnt with no phase loss.
- rst asserted mid-period: the next cycle is the reset state; any pending load is discarded.

Optional Feature:
Macro BAUD_RESYNC_EN.
- Defined: adds input resync, a one-cycle strobe.
  - On resync, the next cycle has cnt = 0, facc = 0 and os_cnt = 0, so rxclk_en and txclk_en both fire one cycle after the strobe.
  - Used by the rx engine to phase-align on a start-bit edge.
  - resync has priority over a tick in the same cycle; rst has priority over resync.
- Not defined: there is no resync port, and the behaviour is exactly as above.

Test Plan:
1. Reset with default parameters, enable = 1 -> rxclk_en on the first cycle after release, then periods 27,27,…,28 with a fractional carry every 8th tick (frac 2/16); 16 rx ticks span 434 cycles; txclk_en on ticks 0,16,32.
2. div_load of int = 4, frac = 0 mid-period -> current period completes unchanged; subsequent periods are 4 cycles; a tx tick every 64 cycles.
3. div_int = 0 and div_int = 1 loaded -> period clamped to 2; rxclk_en is never high on two consecutive cycles.
4. int = 3, frac = 8 (FRAC_BITS = 4) -> periods alternate 3,4; 32 ticks span exactly 112 cycles.
5. enable dropped for 10 cycles mid-period, then restored -> outputs 0 while disabled; the next tick arrives 10 cycles later than it would have without the pause.
6. rst pulsed mid-operation after a pending load -> default divisor restored; pending load discarded; first tick one cycle after release. With BAUD_RESYNC_EN, a resync pulse gives both ticks on the next cycle.

Source files
------------

// File: rtl/uart_baud_gen_frac_if.sv
// Divisor-programming and tick bundle between the UART rx/tx engines and the fractional baud generator.
// BAUD_RESYNC_EN adds the resync strobe used for start-bit phase alignment.
interface uart_baud_gen_frac_if #(
   parameter int unsigned DIV_WIDTH = 16,
   parameter int unsigned FRAC_BITS = 4
);
   logic                 enable;
   logic [DIV_WIDTH-1:0] div_int;
   logic [FRAC_BITS-1:0] div_frac;
   logic                 div_load;
   logic                 rxclk_en;
   logic                 txclk_en;
`ifdef BAUD_RESYNC_EN
   logic                 resync;

   modport master (output enable, div_int, div_frac, div_load, resync,
                   input  rxclk_en, txclk_en);
   modport slave  (input  enable, div_int, div_frac, div_load, resync,
                   output rxclk_en, txclk_en);
`else
   modport master (output enable, div_int, div_frac, div_load,
                   input  rxclk_en, txclk_en);
   modport slave  (input  enable, div_int, div_frac, div_load,
                   output rxclk_en, txclk_en);
`endif
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional-divider UART baud generator: rx oversample tick plus phase-locked tx bit tick.
// Optional macro BAUD_RESYNC_EN adds a resync strobe that restarts the tick grid.
module uart_baud_gen_frac #(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned DEFAULT_BAUD = 115200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned DIV_WIDTH    = 16,
   parameter int unsigned FRAC_BITS    = 4
) (
   input logic                 clk_50m,
   input logic                 rst,
   uart_baud_gen_frac_if.slave bus
);
   localparam int unsigned    OS_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam longint unsigned TICK_HZ = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
   localparam longint unsigned DEF_I64 = 64'(CLK_HZ) / TICK_HZ;
   localparam longint unsigned DEF_F64 = (64'(CLK_HZ) << FRAC_BITS) / TICK_HZ;
   localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_I64);
   localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_F64);
   localparam logic [DIV_WIDTH-1:0] INT_MIN  = DIV_WIDTH'(2);
   localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);

   logic [DIV_WIDTH-1:0] act_int_q,  act_int_d;
   logic [FRAC_BITS-1:0] act_frac_q, act_frac_d;
   logic [DIV_WIDTH-1:0] sh_int_q,   sh_int_d;
   logic [FRAC_BITS-1:0] sh_frac_q,  sh_frac_d;
   logic                 pend_q,     pend_d;
   logic [DIV_WIDTH-1:0] cnt_q,      cnt_d;
   logic [FRAC_BITS-1:0] facc_q,     facc_d;
   logic [OS_W-1:0]      os_cnt_q,   os_cnt_d;

   logic                 rx_tick;
   logic                 tick_upd;
   logic                 resync_c;
   logic [DIV_WIDTH-1:0] sel_int;
   logic [FRAC_BITS-1:0] sel_frac;
   logic [DIV_WIDTH-1:0] int_eff;
   logic [FRAC_BITS:0]   fsum;
   logic [DIV_WIDTH:0]   period;
   logic [DIV_WIDTH:0]   period_m1;

`ifdef BAUD_RESYNC_EN
   assign resync_c = bus.resync;
`else
   assign resync_c = 1'b0;
`endif

   // Tick is a pure decode of the counter so it lands with no added latency.
   assign rx_tick      = bus.enable & ~rst & (cnt_q == '0);
   assign bus.rxclk_en = rx_tick;
   assign bus.txclk_en = rx_tick & (os_cnt_q == '0);

   // Next-period computation and divisor handoff.
   always_comb begin
      act_int_d  = act_int_q;
      act_frac_d = act_frac_q;
      sh_int_d   = sh_int_q;
      sh_frac_d  = sh_frac_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      facc_d     = facc_q;
      os_cnt_d   = os_cnt_q;

      tick_upd = rx_tick & ~resync_c;

      if (bus.div_load) begin
         sel_int  = bus.div_int;
         sel_frac = bus.div_frac;
      end else if (pend_q) begin
         sel_int  = sh_int_q;
         sel_frac = sh_frac_q;
      end else begin
         sel_int  = act_int_q;
         sel_frac = act_frac_q;
      end

      // Clamp keeps every period at least two cycles, so ticks never abut.
      int_eff   = (sel_int < INT_MIN) ? INT_MIN : sel_int;
      fsum      = {1'b0, facc_q} + {1'b0, sel_frac};
      period    = {1'b0, int_eff} + (DIV_WIDTH + 1)'(fsum[FRAC_BITS]);
      period_m1 = period - (DIV_WIDTH + 1)'(1);

      if (resync_c) begin
         cnt_d    = '0;
         facc_d   = '0;
         os_cnt_d = '0;
      end else if (tick_upd) begin
         cnt_d      = DIV_WIDTH'(period_m1);
         facc_d     = fsum[FRAC_BITS-1:0];
         act_int_d  = sel_int;
         act_frac_d = sel_frac;
         pend_d     = 1'b0;
         os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      end else if (bus.enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - DIV_WIDTH'(1);
      end

      // Loads away from a tick wait in the shadow; the running period is untouched.
      if (bus.div_load && !tick_upd) begin
         sh_int_d  = bus.div_int;
         sh_frac_d = bus.div_frac;
         pend_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         act_int_q  <= DEF_INT;
         act_frac_q <= DEF_FRAC;
         sh_int_q   <= DEF_INT;
         sh_frac_q  <= DEF_FRAC;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
         facc_q     <= '0;
         os_cnt_q   <= '0;
      end else begin
         act_int_q  <= act_int_d;
         act_frac_q <= act_frac_d;
         sh_int_q   <= sh_int_d;
         sh_frac_q  <= sh_frac_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         facc_q     <= facc_d;
         os_cnt_q   <= os_cnt_d;
      end
   end
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: tick times predicted as floor(accumulated fractional time),
// compared every cycle, plus directed span/period checks.
module tb_uart_baud_gen_frac;
   localparam int unsigned DW       = 16;
   localparam int unsigned FB       = 4;
   localparam int unsigned OS       = 16;
   localparam int          DEF_INT  = 27;
   localparam int          DEF_FRAC = 2;

   logic clk_50m = 1'b0;
   logic rst     = 1'b1;
   always #5 clk_50m = ~clk_50m;

   uart_baud_gen_frac_if #(.DIV_WIDTH(DW), .FRAC_BITS(FB)) bus ();

   uart_baud_gen_frac #(
      .CLK_HZ(50000000), .DEFAULT_BAUD(115200), .OVERSAMPLE(OS),
      .DIV_WIDTH(DW), .FRAC_BITS(FB)
   ) dut (
      .clk_50m(clk_50m),
      .rst    (rst),
      .bus    (bus.slave)
   );

   int vectors = 0;
   int errs    = 0;
   int cyc_n   = 0;
   bit last_rx = 1'b0;
   bit prev_rx = 1'b0;
   int rx_t[$];
   int tx_t[$];

   // Reference: tick n is due when enabled-cycle count reaches floor(S/2^FB),
   // S being the sum of (clamped int * 2^FB + frac) of divisors chosen at earlier ticks.
   longint m_ecnt, m_s;
   int     m_n, m_ai, m_af, m_si, m_sf;
   bit     m_pend;

   task automatic model_reset();
      m_ecnt = 0; m_s = 0; m_n = 0;
      m_ai = DEF_INT; m_af = DEF_FRAC; m_pend = 1'b0;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic tick_cycle();
      bit er, et, upd, rs, load;
      int si, sf;
      @(negedge clk_50m);
      er = (bus.enable === 1'b1) && (rst === 1'b0) && (m_ecnt == (m_s >> FB));
      et = er && ((m_n % OS) == 0);
      check_bit("rxclk_en", bus.rxclk_en, er);
      check_bit("txclk_en", bus.txclk_en, et);
      check_bit("rx_back_to_back", prev_rx & bus.rxclk_en, 1'b0);
      prev_rx = bus.rxclk_en;
      last_rx = bus.rxclk_en;
      if (bus.rxclk_en === 1'b1) rx_t.push_back(cyc_n);
      if (bus.txclk_en === 1'b1) tx_t.push_back(cyc_n);
`ifdef BAUD_RESYNC_EN
      rs = bus.resync;
`else
      rs = 1'b0;
`endif
      load = bus.div_load;
      if (rst) begin
         model_reset();
      end else begin
         upd = er && !rs;
         if (rs) begin
            m_ecnt = 0; m_s = 0; m_n = 0;
         end else begin
            if (upd) begin
               if (load) begin si = int'(bus.div_int); sf = int'(bus.div_frac); end
               else if (m_pend) begin si = m_si; sf = m_sf; end
               else begin si = m_ai; sf = m_af; end
               m_ai = si; m_af = sf; m_pend = 1'b0;
               m_s += longint'(((si < 2) ? 2 : si) * (1 << FB) + sf);
               m_n++;
            end
            if (bus.enable) m_ecnt++;
         end
         if (load && !upd) begin
            m_si = int'(bus.div_int); m_sf = int'(bus.div_frac); m_pend = 1'b1;
         end
      end
      cyc_n++;
      @(posedge clk_50m);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick_cycle();
   endtask

   task automatic wait_tick(input int max_c, input string tag);
      int k = 0;
      last_rx = 1'b0;
      while (!last_rx && k < max_c) begin
         tick_cycle();
         k++;
      end
      if (!last_rx) check_bit({tag, "_timeout"}, last_rx, 1'b1);
   endtask

   task automatic do_load(input int i, input int f);
      bus.div_int  = DW'(i);
      bus.div_frac = FB'(f);
      bus.div_load = 1'b1;
      tick_cycle();
      bus.div_load = 1'b0;
   endtask

   task automatic clear_q();
      rx_t.delete();
      tx_t.delete();
   endtask

   task automatic check_periods(input string tag, input int count, input int exp);
      if (rx_t.size() < count + 1) check_int({tag, "_ticks"}, rx_t.size(), count + 1);
      else for (int k = 0; k < count; k++) check_int(tag, rx_t[k+1] - rx_t[k], exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, ri, rf, exp_next, gap;
      bus.enable   = 1'b1;
      bus.div_int  = '0;
      bus.div_frac = '0;
      bus.div_load = 1'b0;
`ifdef BAUD_RESYNC_EN
      bus.resync   = 1'b0;
`endif
      model_reset();
      @(posedge clk_50m);
      #1;

      // Reset defaults: 27 + 2/16 cycles per rx tick.
      run(3);
      rst = 1'b0;
      rel = cyc_n;
      clear_q();
      run(900);
      if (rx_t.size() < 33 || tx_t.size() < 3) begin
         check_int("t1_rx_ticks", rx_t.size(), 34);
         check_int("t1_tx_ticks", tx_t.size(), 3);
      end else begin
         check_int("t1_first_tick", rx_t[0], rel);
         check_int("t1_first_tx", tx_t[0], rel);
         for (int k = 0; k < 16; k++)
            check_int("t1_period", rx_t[k+1] - rx_t[k], (k == 7 || k == 15) ? 28 : 27);
         check_int("t1_span16", rx_t[16] - rx_t[0], 434);
         check_int("t1_tx1", tx_t[1], rx_t[16]);
         check_int("t1_tx2", tx_t[2], rx_t[32]);
         check_int("t1_tx_span", tx_t[2] - tx_t[0], 868);
      end

      // Mid-period load of 4.0.
      wait_tick(40, "t2_sync");
      run(5);
      do_load(4, 0);
      clear_q();
      run(300);
      check_periods("t2_period", 60, 4);
      if (tx_t.size() < 3) check_int("t2_tx_ticks", tx_t.size(), 3);
      else begin
         check_int("t2_tx_gap", tx_t[1] - tx_t[0], 64);
         check_int("t2_tx_gap", tx_t[2] - tx_t[1], 64);
      end

      // Integer parts 0 and 1 clamp to 2.
      do_load(0, 0);
      run(10);
      clear_q();
      run(30);
      check_periods("t3_clamp0", 12, 2);
      do_load(1, 0);
      run(10);
      clear_q();
      run(30);
      check_periods("t3_clamp1", 12, 2);

      // 3.5 cycles: alternating 3/4, 32 ticks in 112 cycles.
      do_load(3, 8);
      run(10);
      clear_q();
      run(150);
      if (rx_t.size() < 33) check_int("t4_ticks", rx_t.size(), 33);
      else begin
         check_int("t4_span32", rx_t[32] - rx_t[0], 112);
         for (int k = 0; k < 30; k++)
            check_int("t4_alt", (rx_t[k+1] - rx_t[k]) + (rx_t[k+2] - rx_t[k+1]), 7);
      end

      // Enable pause of 10 cycles mid-period with random divisors.
      repeat (3) begin
         ri = $urandom_range(6, 40);
         rf = $urandom_range(0, 15);
         do_load(ri, rf);
         run(ri * 3 + 10);
         wait_tick(60, "t5_sync");
         run($urandom_range(1, 4));
         exp_next = cyc_n + int'((m_s >> FB) - m_ecnt) + 10;
         bus.enable = 1'b0;
         run(10);
         bus.enable = 1'b1;
         clear_q();
         wait_tick(80, "t5_resume");
         if (rx_t.size() > 0) check_int("t5_resume_time", rx_t[0], exp_next);
      end

      // Random soak: loads (incl. back-to-back overwrites), pauses, runs.
      repeat (40) begin
         if ($urandom_range(0, 2) != 0) begin
            do_load($urandom_range(0, 12), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 12), $urandom_range(0, 15));
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.enable = 1'b0;
            gap = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) do_load($urandom_range(2, 9), $urandom_range(0, 15));
            run(gap);
            bus.enable = 1'b1;
         end
         run($urandom_range(1, 30));
      end

      // Reset with a pending load: defaults return, load discarded.
      do_load(30, 0);
      run(40);
      wait_tick(40, "t6_sync");
      run(3);
      do_load(5, 0);
      run(2);
      rst = 1'b1;
      tick_cycle();
      rst = 1'b0;
      rel = cyc_n;
      clear_q();
      run(60);
      if (rx_t.size() < 2 || tx_t.size() < 1) check_int("t6_ticks", rx_t.size(), 3);
      else begin
         check_int("t6_first_tick", rx_t[0], rel);
         check_int("t6_first_tx", tx_t[0], rel);
         check_int("t6_default_period", rx_t[1] - rx_t[0], DEF_INT);
      end

`ifdef BAUD_RESYNC_EN
      run(5);
      bus.resync = 1'b1;
      tick_cycle();
      bus.resync = 1'b0;
      rel = cyc_n;
      clear_q();
      run(3);
      if (rx_t.size() < 1 || tx_t.size() < 1) check_int("t7_ticks", rx_t.size(), 1);
      else begin
         check_int("t7_resync_rx", rx_t[0], rel);
         check_int("t7_resync_tx", tx_t[0], rel);
      end
      run(60);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
